// File: rtl/ccff_chain_loader_if.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader_if
// Bitstream word handshake between a configuration source and the ccff chain
// loader. A word is transferred on a rising prog_clk edge where both
// word_valid and word_ready are high.
//
//   word_data  : bitstream word, bit WORD_W-1 is shifted into the chain first
//   word_valid : word_data holds a word (driven by the source)
//   word_ready : loader can take a word this cycle (driven by the loader)
//
// Modports: master = bitstream source, slave = loader.
// ----------------------------------------------------------------------------
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready;

   modport master (
      output word_data,
      output word_valid,
      input  word_ready
   );

   modport slave (
      input  word_data,
      input  word_valid,
      output word_ready
   );
endinterface

// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
// Drives a tile's configuration flop chain. Bitstream words arrive over a
// valid/ready handshake and are serialised MSB-first onto ccff_head, one bit
// per enabled prog_clk edge. chain_clk_en drives the chain's clock gate, so
// the chain only advances while a bit is being presented. In a verify pass
// the same bitstream is re-sent and each bit returning on ccff_tail is
// compared with the bit being shifted in.
//
// Ports:
//   prog_clk      configuration clock, all state on the rising edge
//   prog_reset    synchronous active-high reset
//   start         pulse, begins a pass when idle
//   verify        sampled with start: 1 = verify pass, 0 = load pass
//   word_bus      slave side of the bitstream word handshake
//   ccff_head     registered serial bit to the chain head
//   chain_clk_en  registered chain shift enable, aligned with ccff_head
//   ccff_tail     serial bit returning from the chain tail
//   busy          pass in progress
//   done          one-cycle pulse at the end of a pass
//   error         at least one mismatch in the last verify pass
//   err_count     saturating mismatch count of the last verify pass
// ----------------------------------------------------------------------------
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 19,
   parameter int WORD_W    = 8,
   parameter int ERR_W     = 8
) (
   input  logic                  prog_clk,
   input  logic                  prog_reset,
   input  logic                  start,
   input  logic                  verify,
   ccff_chain_loader_if.slave    word_bus,
   output logic                  ccff_head,
   output logic                  chain_clk_en,
   input  logic                  ccff_tail,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ERR_W-1:0]      err_count
);

   // One counter width covers both the chain length and a full word.
   localparam int CNT_MAX = (CHAIN_LEN > WORD_W) ? CHAIN_LEN : WORD_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WORD,
      SHIFT,
      DONE
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic              mode_q;        // 1 = verify pass
   logic [CNT_W-1:0]  bits_left_q;   // chain bits not yet presented this pass
   logic [CNT_W-1:0]  nbits_q;       // bits of the current word still to present
   logic [WORD_W-1:0] sr_q;          // remaining word bits, next one at the MSB
   logic [CNT_W-1:0]  take;

   logic              pass_start;
   logic              accept;
   logic              shift_bit;
   logic              mismatch;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   // Bits taken from the incoming word: a full word, or only the top bits of
   // the final word when the chain length is not a multiple of the word width.
   assign take = (bits_left_q < WORD_CNT) ? bits_left_q : WORD_CNT;

   assign word_bus.word_ready = (state_q == WAIT_WORD);
   assign busy                = (state_q != IDLE);
   assign done                = (state_q == DONE);

   // The tail bit present at an enabled edge is the oldest chain bit, which in
   // a correct chain equals the bit being re-sent on the head.
   assign mismatch = chain_clk_en && mode_q && (ccff_tail != ccff_head);

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pass_start = 1'b0;
      accept     = 1'b0;
      shift_bit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               pass_start = 1'b1;
               state_d    = WAIT_WORD;
            end
         end
         WAIT_WORD: begin
            if (word_bus.word_valid) begin
               accept  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // The accept edge already presented the word's first bit, so
            // nbits_q counts only the bits still following it.
            if (nbits_q != '0) begin
               shift_bit = 1'b1;
            end else if (bits_left_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = WAIT_WORD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         mode_q       <= 1'b0;
         bits_left_q  <= '0;
         nbits_q      <= '0;
         chain_clk_en <= 1'b0;
         ccff_head    <= 1'b0;
         error        <= 1'b0;
         err_count    <= '0;
      end else begin
         // Head bit and enable are registered together so the chain sees a
         // stable bit for the whole enabled cycle.
         chain_clk_en <= accept | shift_bit;

         if (mismatch) begin
            error     <= 1'b1;
            err_count <= sat_inc(err_count);
         end

         if (pass_start) begin
            mode_q      <= verify;
            bits_left_q <= CHAIN_CNT;
            if (verify) begin
               error     <= 1'b0;
               err_count <= '0;
            end
         end

         if (accept) begin
            ccff_head   <= word_bus.word_data[WORD_W-1];
            nbits_q     <= take - CNT_W'(1);
            bits_left_q <= bits_left_q - CNT_W'(1);
         end

         if (shift_bit) begin
            ccff_head   <= sr_q[WORD_W-1];
            nbits_q     <= nbits_q - CNT_W'(1);
            bits_left_q <= bits_left_q - CNT_W'(1);
         end
      end
   end

   // Word shift register: pure data, only meaningful while nbits_q is nonzero.
   always_ff @(posedge prog_clk) begin
      if (accept) begin
         sr_q <= {word_bus.word_data[WORD_W-2:0], 1'b0};
      end else if (shift_bit) begin
         sr_q <= {sr_q[WORD_W-2:0], 1'b0};
      end
   end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain driver sitting directly upstream of a tile's ccff chain: its ccff_head output feeds the first logic block's ccff_head, and the chain's final ccff_tail returns to it.
- Accepts bitstream words over a valid/ready handshake and serialises them MSB-first into the chain, one bit per enabled prog_clk edge.
- Gates chain advance via chain_clk_en, which drives the chain's clock gate.
- Verify pass: the same bitstream is re-sent and each returning tail bit is compared against the bit being shifted in.

Parameters:
- CHAIN_LEN, 19, number of configuration flops in the downstream chain (frac LUT4 17 + output mux 2).
- WORD_W, 8, bitstream word width.
- ERR_W, 8, mismatch counter width.

Ports:
- prog_clk  input  1  configuration clock; all state on rising edge.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a pass when idle.
- verify  input  1  sampled with start; 1 = verify pass, 0 = load pass.
- word_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader can accept a word this cycle.
- ccff_head  output  1  registered serial bit to the chain head.
- chain_clk_en  output  1  registered; chain shifts on the prog_clk edge ending any cycle where this is 1.
- ccff_tail  input  1  serial bit returning from the chain tail.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse at end of pass.
- error  output  1  sticky; at least one mismatch in the last verify pass.
- err_count  output  ERR_W  mismatches in the last verify pass, saturating.

Behaviour:
- Reset values: word_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, error=0, err_count=0. FSM goes to IDLE; bit counters clear.
- Reset mid-pass: the pass is aborted with no done pulse. Chain contents are undefined and a new load pass is required.
- FSM states: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE -> WAIT_WORD on start:
  - latch verify into a mode flag;
  - clear bits_left to CHAIN_LEN;
  - clear error and err_count only if verify=1;
  - busy=1 from the next cycle.
- start is ignored while busy.
- WAIT_WORD: word_ready=1 and chain_clk_en=0.
  - On word_valid & word_ready: load the shift register and set nbits = min(WORD_W, bits_left), then go to SHIFT.
  - Without valid, stay in WAIT_WORD. The chain holds, since no enable is issued.
- SHIFT: word_ready=0. Each cycle, ccff_head = current MSB and chain_clk_en=1, both registered together so they present in the same cycle. Then shift left by one, decrement nbits and bits_left.
  - When nbits reaches 0: go to DONE if bits_left=0, else WAIT_WORD.
  - There is no idle gap inside a word: WORD_W bits occupy WORD_W consecutive enabled cycles.
- Partial last word: with CHAIN_LEN mod WORD_W = r ≠ 0, only the top r bits of the final word are shifted and the low bits are ignored.
- Words per pass = ceil(CHAIN_LEN/WORD_W). The loader never requests an extra word.
- Verify compare: in every cycle with chain_clk_en=1 and mode=verify, compare ccff_tail with ccff_head at that rising edge.
  - ccff_tail at that edge is the oldest chain bit, which equals the bit now being re-sent.
  - On a mismatch: error<=1, err_count<=err_count+1, saturating at 2^ERR_W-1.
  - Load passes never compare and never modify error/err_count.
- DONE: chain_clk_en=0 and done=1 for exactly one cycle, then IDLE with busy=0. ccff_head holds its last value.
- A start arriving in the same cycle as done is ignored. The earliest new start is accepted the first cycle after done, in IDLE.
- Handshake: word_valid may stay high across cycles. No word is taken outside WAIT_WORD. word_data is don't-care when word_valid=0.

Test Plan:
- Load: reset, start verify=0, send 8'hA5, 8'h3C, 8'hE0 back-to-back -> exactly 19 chain_clk_en cycles, ccff_head sequence 1010_0101_0011_1100_111, done pulses one cycle after last enabled cycle, word_ready high exactly 3 times.
- Verify pass: after the load, start verify=1 and resend the same 3 words -> error=0, err_count=0, done pulses once.
- Corrupted verify: resend with word 2 = 8'h3D; the LSB bit is shifted, so 1 bit differs -> error=1, err_count=1. A word 3 change to 8'hE1 touches an ignored padding bit -> err_count unchanged.
- Backpressure: hold word_valid low 5 cycles between words -> chain_clk_en stays 0 during the gap, still exactly 19 enabled cycles total, same head sequence.
- Abuse: pulse start while busy -> ignored, word count unchanged. Assert prog_reset during the 10th shift -> all outputs 0 next cycle, no done. New load completes normally.
- Saturation: ERR_W=2, verify all-inverted bitstream -> err_count saturates at 3, error=1.
